// File: rtl/serial_cmd_decoder.sv
// Decodes 4-word register-write frames from the 9-bit serial receiver,
// verifies the XOR checksum, strobes a register write and returns an ack word.
module serial_cmd_decoder #(
    parameter int unsigned TIMEOUT = 4096,
    parameter logic [7:0]  ACK_NAK = 8'hEE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_newdata,
    input  logic [8:0]  rx_data,
    input  logic        rx_error,
    input  logic        tx_idle,
    output logic [8:0]  tx_data,
    output logic        tx_trigger,
    output logic        reg_wr,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic [7:0]  frame_err,
    output logic        ack_dropped
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_GOT_ADDR = 2'd1;
    localparam logic [1:0] S_GOT_HI   = 2'd2;
    localparam logic [1:0] S_GOT_LO   = 2'd3;

    localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);

    logic [1:0]       state, state_nx;
    logic [7:0]       addr_q, addr_nx, hi_q, hi_nx, lo_q, lo_nx;
    logic [GAP_W-1:0] gap_q, gap_nx;
    logic             err, wr_nx, ack_nx;
    logic [8:0]       ack_word_nx;

    logic             ack_pend;
    logic [8:0]       ack_word;
    logic [1:0]       holdoff;
    logic             issue;

    always_comb begin
        state_nx    = state;
        addr_nx     = addr_q;
        hi_nx       = hi_q;
        lo_nx       = lo_q;
        gap_nx      = gap_q;
        err         = 1'b0;
        wr_nx       = 1'b0;
        ack_nx      = 1'b0;
        ack_word_nx = '0;
        if (rx_error) begin
            err      = 1'b1;
            state_nx = S_IDLE;
            gap_nx   = '0;
        end else if (rx_newdata) begin
            gap_nx = '0;
            if (rx_data[8]) begin
                // A header always (re)starts a frame; mid-frame it also counts as an error
                err      = (state != S_IDLE);
                addr_nx  = rx_data[7:0];
                state_nx = S_GOT_ADDR;
            end else begin
                case (state)
                    S_IDLE:     err = 1'b1;
                    S_GOT_ADDR: begin
                        hi_nx    = rx_data[7:0];
                        state_nx = S_GOT_HI;
                    end
                    S_GOT_HI:   begin
                        lo_nx    = rx_data[7:0];
                        state_nx = S_GOT_LO;
                    end
                    default:    begin
                        state_nx = S_IDLE;
                        ack_nx   = 1'b1;
                        if (rx_data[7:0] == (addr_q ^ hi_q ^ lo_q)) begin
                            wr_nx       = 1'b1;
                            ack_word_nx = {1'b0, addr_q};
                        end else begin
                            err         = 1'b1;
                            ack_word_nx = {1'b0, ACK_NAK};
                        end
                    end
                endcase
            end
        end else if (state != S_IDLE) begin
            if (gap_q == GAP_W'(TIMEOUT - 1)) begin
                err      = 1'b1;
                state_nx = S_IDLE;
                gap_nx   = '0;
            end else begin
                gap_nx = gap_q + 1'b1;
            end
        end
    end

    assign issue = ack_pend && tx_idle && (holdoff == 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            gap_q       <= '0;
            reg_wr      <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            frame_err   <= '0;
            ack_pend    <= 1'b0;
            ack_word    <= '0;
            ack_dropped <= 1'b0;
            holdoff     <= '0;
            tx_trigger  <= 1'b0;
            tx_data     <= '0;
        end else begin
            state  <= state_nx;
            addr_q <= addr_nx;
            hi_q   <= hi_nx;
            lo_q   <= lo_nx;
            gap_q  <= gap_nx;
            reg_wr <= wr_nx;
            if (wr_nx) begin
                reg_addr  <= addr_q;
                reg_wdata <= {hi_q, lo_q};
            end
            if (err && (frame_err != 8'hFF))
                frame_err <= frame_err + 8'd1;

            tx_trigger <= issue;
            if (issue) begin
                tx_data <= ack_word;
                holdoff <= 2'd2;
            end else if (holdoff != 2'd0) begin
                holdoff <= holdoff - 2'd1;
            end

            // A new ack arriving while the old one goes out this cycle is not a drop
            if (ack_nx) begin
                ack_pend <= 1'b1;
                ack_word <= ack_word_nx;
                if (ack_pend && !issue)
                    ack_dropped <= 1'b1;
            end else if (issue) begin
                ack_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_cmd_decoder.sv
// Scoreboard bench for serial_cmd_decoder: a frame-level reference model queues
// expected writes/acks; a monitor pops and compares whenever the DUT emits them.
module tb_serial_cmd_decoder;

    localparam int unsigned TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_newdata = 1'b0;
    logic [8:0]  rx_data = '0;
    logic        rx_error = 1'b0;
    logic        tx_idle = 1'b1;
    logic [8:0]  tx_data;
    logic        tx_trigger;
    logic        reg_wr;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [7:0]  frame_err;
    logic        ack_dropped;

    serial_cmd_decoder #(.TIMEOUT(TIMEOUT), .ACK_NAK(8'hEE)) dut (
        .clk(clk), .rst(rst), .rx_newdata(rx_newdata), .rx_data(rx_data),
        .rx_error(rx_error), .tx_idle(tx_idle), .tx_data(tx_data),
        .tx_trigger(tx_trigger), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .frame_err(frame_err), .ack_dropped(ack_dropped)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
        int unsigned c;
    } wr_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    wr_t         exp_wr[$];
    logic [8:0]  exp_ack[$];
    logic [7:0]  cur[$];
    int unsigned last_s = 0;
    int          m_err = 0;
    bit          m_drop = 1'b0;
    bit          hold = 1'b0;
    bit          slot_v = 1'b0;
    logic [8:0]  slot = '0;
    bit          mon_en = 1'b0;
    wr_t         mon_w;
    logic [8:0]  mon_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (reg_wr) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL reg_wr_unexpected: got addr %0h data %0h expected none", reg_addr, reg_wdata);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("reg_addr", 32'(reg_addr), 32'(mon_w.a));
                    check("reg_wdata", 32'(reg_wdata), 32'(mon_w.d));
                    check("reg_wr_cycle", cyc, mon_w.c);
                end
            end
            if (tx_trigger) begin
                if (exp_ack.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_trigger_unexpected: got tx_data %0h expected none", tx_data);
                end else begin
                    mon_a = exp_ack.pop_front();
                    check("tx_data", 32'(tx_data), 32'(mon_a));
                end
            end
        end
    end

    function automatic void bump();
        if (m_err < 255) m_err++;
    endfunction

    function automatic void model_ack(input logic [8:0] w);
        if (hold) begin
            if (slot_v) m_drop = 1'b1;
            slot   = w;
            slot_v = 1'b1;
        end else begin
            exp_ack.push_back(w);
        end
    endfunction

    // Frame-level view: a frame is the list of words collected since its header
    function automatic void model_word(input logic [8:0] w, input bit e, input int unsigned s);
        wr_t x;
        if (e) begin
            bump();
            cur.delete();
            return;
        end
        if (cur.size() > 0 && (s - last_s) > TIMEOUT) begin
            bump();
            cur.delete();
        end
        last_s = s;
        if (w[8]) begin
            if (cur.size() > 0) bump();
            cur.delete();
            cur.push_back(w[7:0]);
        end else if (cur.size() == 0) begin
            bump();
        end else begin
            cur.push_back(w[7:0]);
            if (cur.size() == 4) begin
                if (cur[3] == (cur[0] ^ cur[1] ^ cur[2])) begin
                    x.a = cur[0];
                    x.d = {cur[1], cur[2]};
                    x.c = s;
                    exp_wr.push_back(x);
                    model_ack({1'b0, cur[0]});
                end else begin
                    bump();
                    model_ack(9'h0EE);
                end
                cur.delete();
            end
        end
    endfunction

    task automatic send(input logic [8:0] w, input bit e, input int unsigned gap);
        repeat (gap) @(posedge clk);
        @(posedge clk);
        #2;
        rx_newdata = 1'b1;
        rx_data    = w;
        rx_error   = e;
        @(posedge clk);
        #2;
        rx_newdata = 1'b0;
        rx_error   = 1'b0;
        rx_data    = '0;
        model_word(w, e, cyc);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l, input logic [7:0] c);
        send({1'b1, a}, 1'b0, 1);
        send({1'b0, h}, 1'b0, 1);
        send({1'b0, l}, 1'b0, 1);
        send({1'b0, c}, 1'b0, 1);
    endtask

    task automatic check_status(input string tag);
        repeat (20) @(posedge clk);
        #2;
        check({tag, "_frame_err"}, 32'(frame_err), 32'(m_err));
        check({tag, "_ack_dropped"}, 32'(ack_dropped), 32'(m_drop));
        check({tag, "_pending_writes"}, 32'(exp_wr.size()), 32'd0);
        check({tag, "_pending_acks"}, 32'(exp_ack.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_tx_trigger"}, 32'(tx_trigger), 32'd0);
        check({tag, "_reg_wr"}, 32'(reg_wr), 32'd0);
        check({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
        check({tag, "_reg_wdata"}, 32'(reg_wdata), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_ack_dropped"}, 32'(ack_dropped), 32'd0);
    endtask

    initial begin
        logic [8:0]  w[4];
        bit          e[4];
        int unsigned r, p;
        logic [7:0]  a, h, l;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        rst    = 1'b1;
        mon_en = 1'b1;

        send_frame(8'h12, 8'hAB, 8'hCD, 8'h74);
        check_status("good_frame");
        send_frame(8'h12, 8'hAB, 8'hCD, 8'h75);
        check_status("bad_checksum");

        send(9'h112, 1'b0, 1);
        send(9'h0AB, 1'b0, 1);
        send_frame(8'h34, 8'h01, 8'h02, 8'h37);
        check_status("header_restart");

        send(9'h112, 1'b0, 1);
        send(9'h0AB, 1'b0, 1);
        send(9'h0CD, 1'b0, 5000);
        check_status("timeout");

        tx_idle = 1'b0;
        hold    = 1'b1;
        send_frame(8'h21, 8'h11, 8'h22, 8'h21 ^ 8'h11 ^ 8'h22);
        send_frame(8'h43, 8'h33, 8'h44, 8'h43 ^ 8'h33 ^ 8'h44);
        check_status("ack_held");
        hold = 1'b0;
        if (slot_v) exp_ack.push_back(slot);
        slot_v  = 1'b0;
        tx_idle = 1'b1;
        check_status("ack_release");

        send(9'h156, 1'b0, 1);
        send(9'h001, 1'b0, 1);
        send(9'h000, 1'b1, 1);
        send(9'h002, 1'b0, 1);
        send(9'h055, 1'b0, 1);
        check_status("rx_error");

        send(9'h178, 1'b0, 1);
        send(9'h0A5, 1'b0, 1);
        send(9'h05A, 1'b0, 1);
        check_status("pre_reset");
        mon_en = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        check_reset_outputs("midframe_reset");
        cur.delete();
        m_err  = 0;
        m_drop = 1'b0;
        @(posedge clk);
        #2;
        rst    = 1'b1;
        mon_en = 1'b1;
        send(9'h0C3, 1'b0, 1);
        send_frame(8'h9A, 8'hFE, 8'h01, 8'h9A ^ 8'hFE ^ 8'h01);
        check_status("post_reset");

        for (int f = 0; f < 150; f++) begin
            a = 8'($urandom);
            h = 8'($urandom);
            l = 8'($urandom);
            w[0] = {1'b1, a};
            w[1] = {1'b0, h};
            w[2] = {1'b0, l};
            w[3] = {1'b0, a ^ h ^ l};
            for (int i = 0; i < 4; i++) e[i] = 1'b0;
            r = $urandom_range(0, 29);
            p = $urandom_range(1, 3);
            if (r == 0) w[3] = w[3] ^ {1'b0, 8'($urandom_range(1, 255))};
            if (r == 2) e[$urandom_range(0, 3)] = 1'b1;
            if (r == 4) send({1'b0, 8'($urandom)}, 1'b0, $urandom_range(0, 3));
            for (int i = 0; i < 4; i++) begin
                if (r == 1 && i == int'(p))
                    send({1'b1, 8'($urandom)}, 1'b0, $urandom_range(0, 3));
                send(w[i], e[i], (r == 3 && i == int'(p)) ? 5000 : $urandom_range(0, 3));
            end
        end
        check_status("random");

        for (int i = 0; i < 270; i++) send({1'b0, 8'($urandom)}, 1'b0, 0);
        check_status("saturate");
        check("saturate_value", 32'(frame_err), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
